// File: rtl/cache_miss_controller_if.sv
// Pipeline/tag-array/memory signal bundle for the cache miss controller.
// The slave modport is the controller's view; master is the surrounding pipeline and memory.
interface cache_miss_controller_if #(
    parameter int INDEX_BITS = 6
);
    localparam int TAG_W = 28 - INDEX_BITS;

    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       addr;
    logic              tagMatch;
    logic              lineValid;
    logic              lineDirty;
    logic [TAG_W-1:0]  victimTag;
    logic              memAck;
    logic              hit;
    logic              memReq;
    logic              memWe;
    logic [31:0]       memAddr;
    logic [1:0]        wordSel;
    logic              fillWe;
    logic              tagWe;
    logic              dirtySet;
    logic [15:0]       missCount;

    modport slave (
        input  MemRead, MemWrite, addr, tagMatch, lineValid, lineDirty, victimTag, memAck,
        output hit, memReq, memWe, memAddr, wordSel, fillWe, tagWe, dirtySet, missCount
    );

    modport master (
        output MemRead, MemWrite, addr, tagMatch, lineValid, lineDirty, victimTag, memAck,
        input  hit, memReq, memWe, memAddr, wordSel, fillWe, tagWe, dirtySet, missCount
    );
endinterface

// File: rtl/cache_miss_controller.sv
// Direct-mapped, write-back cache miss controller: hit detection, 4-word victim
// writeback, 4-word line fill, tag update, and a saturating miss counter.
module cache_miss_controller #(
    parameter int INDEX_BITS = 6
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    cache_miss_controller_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_word_cnt;
    logic [1:0]  w_word_cnt_next;
    logic [31:4] r_miss_addr;
    logic [15:0] r_miss_count;
    logic        w_capture;
    logic        w_access;
    logic        w_line_hit;
    logic        w_unused_addr_bits;

    assign w_access           = bus.MemRead | bus.MemWrite;
    assign w_line_hit         = bus.tagMatch & bus.lineValid;
    assign w_unused_addr_bits = ^bus.addr[3:0];
    assign bus.missCount      = r_miss_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_word_cnt   <= 2'd0;
            r_miss_addr  <= '0;
            r_miss_count <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_word_cnt <= w_word_cnt_next;
            if (w_capture) begin
                r_miss_addr <= bus.addr[31:4];
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    // Outputs decode from registered state, so an async reset clears them with no clock edge.
    always_comb begin
        w_state_next    = r_state;
        w_word_cnt_next = r_word_cnt;
        w_capture       = 1'b0;
        bus.hit         = 1'b0;
        bus.memReq      = 1'b0;
        bus.memWe       = 1'b0;
        bus.memAddr     = '0;
        bus.wordSel     = 2'd0;
        bus.fillWe      = 1'b0;
        bus.tagWe       = 1'b0;
        bus.dirtySet    = 1'b0;
        case (r_state)
            IDLE: begin
                bus.hit = 1'b1;
                if (w_access) begin
                    if (w_line_hit) begin
                        bus.dirtySet = bus.MemWrite;
                    end else begin
                        bus.hit      = 1'b0;
                        w_capture    = 1'b1;
                        w_state_next = (bus.lineValid && bus.lineDirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.memReq  = 1'b1;
                bus.memWe   = 1'b1;
                bus.memAddr = {bus.victimTag, r_miss_addr[3+INDEX_BITS:4], r_word_cnt, 2'b00};
                bus.wordSel = r_word_cnt;
                if (bus.memAck) begin
                    w_word_cnt_next = r_word_cnt + 2'd1;
                    if (r_word_cnt == 2'd3) begin
                        w_state_next = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                bus.memReq  = 1'b1;
                bus.memAddr = {r_miss_addr, r_word_cnt, 2'b00};
                bus.wordSel = r_word_cnt;
                bus.fillWe  = bus.memAck;
                if (bus.memAck) begin
                    w_word_cnt_next = r_word_cnt + 2'd1;
                    if (r_word_cnt == 2'd3) begin
                        w_state_next = UPDATE;
                    end
                end
            end
            UPDATE: begin
                bus.tagWe    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_miss_controller.sv
// Scoreboard bench for cache_miss_controller: expected memory beats are queued
// when a miss is presented and retired as the controller issues them.
module tb_cache_miss_controller;
    localparam int IB   = 6;
    localparam int TAGW = 28 - IB;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  ws;
    } txn_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    txn_t sb_q[$];

    cache_miss_controller_if #(.INDEX_BITS(IB)) bus ();

    cache_miss_controller #(.INDEX_BITS(IB)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.tagMatch  = 1'b0;
        bus.lineValid = 1'b0;
        bus.lineDirty = 1'b0;
        bus.memAck    = 1'b0;
    endtask

    // Present a missing access, serve memory with the given ack pattern, and retire queued beats.
    task automatic run_miss(input logic [31:0] a, input logic rd, input logic wr, input logic dirty,
                            input logic [TAGW-1:0] vtag, input logic [15:0] ack_pat, input int pat_len,
                            input int exp_low, input logic [15:0] exp_cnt);
        txn_t e;
        int   low;
        int   tagwe_n;
        int   idx;
        logic line_upd;
        logic got_hit;
        sb_q.delete();
        if (dirty) begin
            for (int w = 0; w < 4; w++) begin
                e.we = 1'b1; e.ws = 2'(w);
                e.addr = {vtag, a[IB+3:4], 2'(w), 2'b00};
                sb_q.push_back(e);
            end
        end
        for (int w = 0; w < 4; w++) begin
            e.we = 1'b0; e.ws = 2'(w);
            e.addr = {a[31:4], 2'(w), 2'b00};
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.addr      = a;
        bus.tagMatch  = 1'b0;
        bus.lineValid = dirty;
        bus.lineDirty = 1'b1;
        bus.victimTag = vtag;
        #1 bus.memAck = 1'b1;
        #1;
        chk("miss_hit_low", {31'd0, bus.hit}, 32'd0);
        chk("miss_idle_memreq", {31'd0, bus.memReq}, 32'd0);
        low = 1; tagwe_n = 0; idx = 0; line_upd = 1'b0; got_hit = 1'b0;
        for (int cyc = 0; cyc < 60 && !got_hit; cyc++) begin
            @(negedge clk);
            if (line_upd) begin
                bus.tagMatch  = 1'b1;
                bus.lineValid = 1'b1;
                bus.lineDirty = 1'b0;
                bus.addr      = a;
            end else begin
                bus.addr = $urandom;
            end
            #1;
            if (bus.memReq) begin
                bus.memAck = ack_pat[idx % pat_len];
                idx++;
            end else begin
                bus.memAck = 1'($urandom_range(1, 0));
            end
            #1;
            if (bus.hit) begin
                got_hit = 1'b1;
            end else begin
                low++;
                if (bus.memReq) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q[0];
                        chk("beat_we", {31'd0, bus.memWe}, {31'd0, e.we});
                        chk("beat_addr", bus.memAddr, e.addr);
                        chk("beat_wordsel", {30'd0, bus.wordSel}, {30'd0, e.ws});
                        chk("beat_fillwe", {31'd0, bus.fillWe}, {31'd0, (~e.we) & bus.memAck});
                        if (bus.memAck) void'(sb_q.pop_front());
                    end
                end else begin
                    chk("nobeat_fillwe", {31'd0, bus.fillWe}, 32'd0);
                end
                if (bus.tagWe) begin
                    tagwe_n++;
                    line_upd = 1'b1;
                end
            end
        end
        chk("miss_done_in_time", {31'd0, got_hit}, 32'd1);
        chk("hit_low_cycles", 32'(low), 32'(exp_low));
        chk("tagwe_cycles", 32'(tagwe_n), 32'd1);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("represent_dirtyset", {31'd0, bus.dirtySet}, {31'd0, wr});
        chk("represent_memreq", {31'd0, bus.memReq}, 32'd0);
        $display("miss addr=0x%08h wr=%0b dirty=%0b hit_low=%0d tagWe=%0d", a, wr, dirty, low, tagwe_n);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("miss_count", {16'd0, bus.missCount}, {16'd0, exp_cnt});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle_inputs();
        bus.addr      = 32'd0;
        bus.victimTag = '0;
        #2;
        chk("reset_hit", {31'd0, bus.hit}, 32'd1);
        chk("reset_memreq", {31'd0, bus.memReq}, 32'd0);
        chk("reset_misscount", {16'd0, bus.missCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.MemRead = 1'b1; bus.tagMatch = 1'b1; bus.lineValid = 1'b1; bus.addr = 32'h0000_0100;
        #2;
        chk("rd_hit", {31'd0, bus.hit}, 32'd1);
        chk("rd_hit_memreq", {31'd0, bus.memReq}, 32'd0);
        chk("rd_hit_dirtyset", {31'd0, bus.dirtySet}, 32'd0);
        $display("read hit addr=0x%08h hit=%0b", bus.addr, bus.hit);
        @(negedge clk);
        bus.MemWrite = 1'b1;
        #2;
        chk("rdwr_hit", {31'd0, bus.hit}, 32'd1);
        chk("rdwr_hit_dirtyset", {31'd0, bus.dirtySet}, 32'd1);
        $display("read+write hit addr=0x%08h dirtySet=%0b", bus.addr, bus.dirtySet);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("idle_hit", {31'd0, bus.hit}, 32'd1);
        chk("hits_misscount", {16'd0, bus.missCount}, 32'd0);

        run_miss(32'h0000_1234, 1'b1, 1'b0, 1'b0, '0, 16'h0001, 1, 6, 16'd1);
        run_miss(32'h0004_0038, 1'b0, 1'b1, 1'b1, 22'h00ABC, 16'h0001, 1, 10, 16'd2);
        run_miss(32'h0000_5670, 1'b1, 1'b0, 1'b0, '0, 16'h0069, 7, 9, 16'd3);

        // Reset pulse in the middle of a writeback burst.
        @(negedge clk);
        bus.MemWrite = 1'b1; bus.addr = 32'h0008_0038; bus.lineValid = 1'b1; bus.lineDirty = 1'b1;
        bus.victimTag = 22'h00123; bus.memAck = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("wb_w2_memreq", {31'd0, bus.memReq}, 32'd1);
        chk("wb_w2_wordsel", {30'd0, bus.wordSel}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_memreq", {31'd0, bus.memReq}, 32'd0);
        chk("async_rst_memwe", {31'd0, bus.memWe}, 32'd0);
        chk("async_rst_misscount", {16'd0, bus.missCount}, 32'd0);
        idle_inputs();
        #1;
        chk("async_rst_hit", {31'd0, bus.hit}, 32'd1);
        $display("async reset mid-writeback memReq=%0b hit=%0b", bus.memReq, bus.hit);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_hit", {31'd0, bus.hit}, 32'd1);
        chk("post_rst_memreq", {31'd0, bus.memReq}, 32'd0);
        chk("post_rst_misscount", {16'd0, bus.missCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
